// File: rtl/alu_ctrl.sv
// Instruction-side controller for the 4-bit ALU: register file, operand fetch, write-back.
// Optional zero flag output is compiled in when ALU_ZERO_FLAG_EN is defined.
module alu_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3+3*AW-1:0] instr,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [2:0]        alu_sel,
    input  logic [WIDTH-1:0]  alu_out,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    input  logic [AW-1:0]     dbg_raddr,
    output logic [WIDTH-1:0]  dbg_rdata
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
    localparam logic [2:0] OP_LOADI = 3'b111;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_rf [DEPTH];
    logic [WIDTH-1:0] r_aluIn1;
    logic [WIDTH-1:0] r_aluIn2;
    logic [2:0]       r_aluSel;
    logic [AW-1:0]    r_rd;
    logic             r_isLoadi;
    logic [WIDTH-1:0] r_imm;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic [2:0]       w_op;
    logic [AW-1:0]    w_rd;
    logic [AW-1:0]    w_rs1;
    logic [AW-1:0]    w_rs2;
    logic             w_accept;
    logic             w_rs1Ok;
    logic             w_rs2Ok;
    logic             w_rdOk;
    logic             w_dbgOk;
    logic [WIDTH-1:0] w_rs1Data;
    logic [WIDTH-1:0] w_rs2Data;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_wbData;

    assign w_op  = instr[3+3*AW-1 -: 3];
    assign w_rd  = instr[3*AW-1 -: AW];
    assign w_rs1 = instr[2*AW-1 -: AW];
    assign w_rs2 = instr[AW-1:0];

    // Indices beyond NREGS only occur when NREGS is not a power of two.
    assign w_rs1Ok = {1'b0, w_rs1} < NREGS_W;
    assign w_rs2Ok = {1'b0, w_rs2} < NREGS_W;
    assign w_rdOk  = {1'b0, r_rd} < NREGS_W;
    assign w_dbgOk = {1'b0, dbg_raddr} < NREGS_W;

    assign w_rs1Data = w_rs1Ok ? r_rf[w_rs1] : '0;
    assign w_rs2Data = w_rs2Ok ? r_rf[w_rs2] : '0;
    assign dbg_rdata = w_dbgOk ? r_rf[dbg_raddr] : '0;

    assign w_imm    = WIDTH'({w_rs1, w_rs2});
    assign w_accept = instr_valid & instr_ready;
    assign w_wbData = r_isLoadi ? r_imm : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        instr_ready = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // LOADI leaves the ALU-facing registers untouched; only the immediate is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_aluIn1  <= '0;
            r_aluIn2  <= '0;
            r_aluSel  <= 3'b000;
            r_rd      <= '0;
            r_isLoadi <= 1'b0;
            r_imm     <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rd      <= w_rd;
                r_isLoadi <= (w_op == OP_LOADI);
                r_imm     <= w_imm;
                if (w_op != OP_LOADI) begin
                    r_aluIn1 <= w_rs1Data;
                    r_aluIn2 <= w_rs2Data;
                    r_aluSel <= w_op;
                end
            end
            if (r_state == EXEC) begin
                if (w_rdOk) begin
                    r_rf[r_rd] <= w_wbData;
                end
                r_result <= w_wbData;
                r_done   <= 1'b1;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (r_state == EXEC) begin
            r_zero <= (w_wbData == '0);
        end
    end

    assign zero = r_zero;
`endif

    assign alu_in1 = r_aluIn1;
    assign alu_in2 = r_aluIn2;
    assign alu_sel = r_aluSel;
    assign done    = r_done;
    assign result  = r_result;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with an adder stub ALU; zero flag checked when ALU_ZERO_FLAG_EN is set.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [8:0] instr = '0;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       done;
    logic [3:0] result;
    logic [1:0] dbg_raddr = '0;
    logic [3:0] dbg_rdata;
`ifdef ALU_ZERO_FLAG_EN
    logic       zero;
`endif

    alu_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_sel(alu_sel),
        .alu_out(alu_out),
        .done(done),
        .result(result),
        .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    // Stub ALU: plain 4-bit add, select ignored.
    assign alu_out = alu_in1 + alu_in2;

    typedef struct {
        int value;
        int in1;
        int in2;
        int sel;
        int zero;
    } exp_t;

    exp_t expQ[$];

    int vecCnt = 0;
    int missCnt = 0;
    int cycleCnt = 0;
    int lastAccept = 0;

    logic [3:0] mRf [4];
    logic [3:0] mIn1 = '0;
    logic [3:0] mIn2 = '0;
    logic [2:0] mSel = '0;
    logic [3:0] mResult = '0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        vecCnt++;
        if (act != exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4; i++) mRf[i] = '0;
        mIn1 = '0;
        mIn2 = '0;
        mSel = '0;
        mResult = '0;
        expQ.delete();
    endtask

    // Offers one instruction, updates the reference model at the accept edge and queues the expectation.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input bit keepValid, input bit checkSpacing);
        int waitCnt;
        logic [3:0] val;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        instr = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        while (!instr_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!instr_ready) begin
            vecCnt++;
            missCnt++;
            $display("[TB] FAIL accept_timeout: got no instr_ready, expected accept within 20 cycles");
            instr_valid = 1'b0;
            return;
        end
        if (checkSpacing) checkOutput("b2b_spacing", cycleCnt - lastAccept, 2);
        lastAccept = cycleCnt;
        if (op == 3'b111) begin
            val = {rs1, rs2};
        end else begin
            mIn1 = mRf[rs1];
            mIn2 = mRf[rs2];
            mSel = op;
            val = mIn1 + mIn2;
        end
        mRf[rd] = val;
        mResult = val;
        e.value = int'(val);
        e.in1 = int'(mIn1);
        e.in2 = int'(mIn2);
        e.sel = int'(mSel);
        e.zero = (val == 4'h0) ? 1 : 0;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("ready_in_exec", int'(instr_ready), 0);
        if (!keepValid) instr_valid = 1'b0;
    endtask

    task automatic checkReg(input logic [1:0] idx, input logic [3:0] exp);
        @(negedge clk);
        dbg_raddr = idx;
        #1;
        checkOutput($sformatf("rf_r%0d", idx), int'(dbg_rdata), int'(exp));
    endtask

    task automatic drain();
        int waitCnt;
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("scoreboard_drain", expQ.size(), 0);
    endtask

    // Monitor: every retirement pops one expectation and compares the visible outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (expQ.size() == 0) begin
                    vecCnt++;
                    missCnt++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no retirement pending");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result", int'(result), e.value);
                    checkOutput("alu_in1", int'(alu_in1), e.in1);
                    checkOutput("alu_in2", int'(alu_in2), e.in2);
                    checkOutput("alu_sel", int'(alu_sel), e.sel);
`ifdef ALU_ZERO_FLAG_EN
                    checkOutput("zero", int'(zero), e.zero);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", int'(instr_ready), 1);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_alu_in1", int'(alu_in1), 0);
        checkOutput("reset_alu_sel", int'(alu_sel), 0);
        checkOutput("reset_result", int'(result), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) checkReg(2'(i), 4'h0);

        applyStimulus(3'b111, 2'd0, 2'b01, 2'b00, 1'b0, 1'b0);
        applyStimulus(3'b111, 2'd1, 2'b10, 2'b01, 1'b0, 1'b0);
        drain();
        checkReg(2'd0, 4'h4);
        checkReg(2'd1, 4'h9);

        applyStimulus(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
        applyStimulus(3'b000, 2'd3, 2'd1, 2'd1, 1'b0, 1'b0);
        drain();
        checkReg(2'd2, 4'hD);
        checkReg(2'd3, 4'h2);

        applyStimulus(3'b111, 2'd3, 2'b00, 2'b00, 1'b0, 1'b0);
        applyStimulus(3'b010, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
        drain();

        applyStimulus(3'b111, 2'd1, 2'b11, 2'b11, 1'b1, 1'b0);
        applyStimulus(3'b001, 2'd1, 2'd1, 2'd0, 1'b1, 1'b1);
        applyStimulus(3'b011, 2'd3, 2'd1, 2'd1, 1'b0, 1'b1);
        drain();

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_done", int'(done), 0);
            checkOutput("stall_result", int'(result), int'(mResult));
            checkOutput("stall_alu_in1", int'(alu_in1), int'(mIn1));
        end
        for (int i = 0; i < 4; i++) checkReg(2'(i), mRf[i]);

        @(negedge clk);
        instr = {3'b111, 2'd2, 2'b01, 2'b01};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checkOutput("pre_reset_busy", int'(instr_ready), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", int'(instr_ready), 1);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_result", int'(result), 0);
        checkOutput("midreset_alu_in2", int'(alu_in2), 0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) checkReg(2'(i), 4'h0);

        applyStimulus(3'b111, 2'd2, 2'b01, 2'b01, 1'b0, 1'b0);
        drain();
        checkReg(2'd2, 4'h5);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
